regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file; next generation of the core regfile.
//  Two combinational read ports, two synchronous write ports with fixed priority,
//  same-cycle write-to-read bypass, optional hardwired zero register, and a post-reset
//  clear sweep that zeroes every entry. Sits between decode (reads) and writeback (writes).
// PARAMETERS
//  XLEN      32  data width in bits
//  NREGS     32  number of architectural registers (power of 2, >=2)
//  AW        $clog2(NREGS)  address width (derived, do not override)
//  ZERO_REG  1   1: entry 0 always reads 0 and ignores writes; 0: entry 0 is ordinary
// PORTS
//  clk      in   1     clock, all state updates on posedge
//  rst      in   1     synchronous active-high reset
//  ready    out  1     1 = clear sweep done, file usable
//  r1       in   AW    read address port 1
//  r2       in   AW    read address port 2
//  rout1    out  XLEN  read data port 1 (combinational)
//  rout2    out  XLEN  read data port 2 (combinational)
//  wr_en0   in   1     write enable port 0
//  w0       in   AW    write address port 0
//  data0    in   XLEN  write data port 0
//  wr_en1   in   1     write enable port 1 (higher priority)
//  w1       in   AW    write address port 1
//  data1    in   XLEN  write data port 1
// BEHAVIOUR
//  - FSM states: CLEAR, RUN. rst=1 -> state CLEAR, clr_idx=0, ready=0 (next edge).
//  - CLEAR (rst=0): each cycle write 0 to regs[clr_idx], clr_idx++; after entry NREGS-1
//    is cleared -> RUN, ready=1 next cycle. Sweep takes exactly NREGS cycles after rst drops.
//  - rst reasserted mid-sweep restarts sweep at clr_idx=0. rst in RUN -> back to CLEAR.
//  - In CLEAR: wr_en0/wr_en1 ignored; rout1/rout2 forced to 0.
//  - In RUN: wr_enN=1 writes dataN to regs[wN] at posedge. Both enabled, same address:
//    port 1 wins, port 0 dropped. Different addresses: both written.
//  - ZERO_REG=1: writes to address 0 discarded; reads of address 0 return 0 (also no bypass).
//  - Read: rout = bypass if a RUN-state write enable targets the read address this cycle
//    (port 1 data over port 0), else regs[r]. Zero-latency, no pipelining.
//  - Reset value: ready=0; rout1/rout2=0 throughout reset and sweep; no ports X after sweep.
//  - Addresses are full AW bits; no out-of-range entries since NREGS is a power of 2.
// CONFIGURATION
//  REGFILE_SCOREBOARD_EN defined: adds ports
//    alloc_en in 1, alloc_addr in AW: set busy[alloc_addr] at posedge (RUN only)
//    busy1 out 1, busy2 out 1: busy bit of r1 / r2 (combinational)
//    busy[] cleared to 0 by rst and held 0 during CLEAR; write to addr clears its bit;
//    write and alloc to same addr same cycle -> busy ends set (alloc wins);
//    ZERO_REG=1: busy[0] never set. busy1/busy2 reflect the registered busy bits only
//    (no same-cycle bypass of alloc or write).
//  Not defined: no busy storage, no extra ports; core file behaviour identical.
// TESTING
//  1. rst 1 cycle then low: ready=0 for 32 cycles, ready=1 on cycle 33; all 32 reads = 0.
//  2. RUN: wr_en0 w0=5 data0=0xDEADBEEF, r1=5 same cycle -> rout1=0xDEADBEEF (bypass);
//     next cycle no write, rout1=0xDEADBEEF.
//  3. Both ports w0=w1=7, data0=0x11, data1=0x22 -> rout at addr 7 = 0x22 same & next cycle.
//  4. ZERO_REG=1: write 0xFFFFFFFF to addr 0 -> r1=0 reads 0 same and next cycle.
//  5. rst pulsed at sweep cycle 10 -> ready rises exactly 32 cycles after rst falls;
//     writes issued during sweep leave registers 0.
//  6. REGFILE_SCOREBOARD_EN: alloc addr 3 -> busy1=1 (r1=3) next cycle; write addr 3
//     -> busy1=0 next cycle; alloc+write addr 3 same cycle -> busy1=1.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write ports and the ready flag.
// With REGFILE_SCOREBOARD_EN defined the bundle also carries the
// allocate request and the two busy indications.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            ready;
  logic [AW-1:0]   r1;
  logic [AW-1:0]   r2;
  logic [XLEN-1:0] rout1;
  logic [XLEN-1:0] rout2;
  logic            wr_en0;
  logic [AW-1:0]   w0;
  logic [XLEN-1:0] data0;
  logic            wr_en1;
  logic [AW-1:0]   w1;
  logic [XLEN-1:0] data1;
`ifdef REGFILE_SCOREBOARD_EN
  logic            alloc_en;
  logic [AW-1:0]   alloc_addr;
  logic            busy1;
  logic            busy2;

  modport master (
    input  ready, rout1, rout2, busy1, busy2,
    output r1, r2, wr_en0, w0, data0, wr_en1, w1, data1, alloc_en, alloc_addr
  );
  modport slave (
    output ready, rout1, rout2, busy1, busy2,
    input  r1, r2, wr_en0, w0, data0, wr_en1, w1, data1, alloc_en, alloc_addr
  );
`else
  modport master (
    input  ready, rout1, rout2,
    output r1, r2, wr_en0, w0, data0, wr_en1, w1, data1
  );
  modport slave (
    output ready, rout1, rout2,
    input  r1, r2, wr_en0, w0, data0, wr_en1, w1, data1
  );
`endif
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file.
// Two combinational read ports with same-cycle write bypass, two write
// ports (port 1 wins on an address collision), optional hardwired zero
// entry, and a clear sweep after reset that zeroes every entry before
// ready is raised.
// Optional feature: define REGFILE_SCOREBOARD_EN to add per-register busy
// bits (alloc_en/alloc_addr set a bit, a write clears it, busy1/busy2
// report the registered bit for r1/r2).
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
  input logic        clk,
  input logic        rst,
  regfile_mp_if.slave rf
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [XLEN-1:0] regs_q [NREGS];

  logic [AW-1:0]   r1_a, r2_a, w0_a, w1_a;
  logic [XLEN-1:0] data0_v, data1_v;
  logic            run;
  logic            we0, we1;
  logic [XLEN-1:0] rout1_v, rout2_v;

  assign r1_a    = rf.r1;
  assign r2_a    = rf.r2;
  assign w0_a    = rf.w0;
  assign w1_a    = rf.w1;
  assign data0_v = rf.data0;
  assign data1_v = rf.data1;

  // Port activity is only honoured in RUN with reset released; reads are
  // forced to zero under the same condition.
  assign run = (state_q == RUN) && !rst;

  // Effective write enables: zero-entry writes discarded, port 0 dropped
  // when port 1 targets the same address.
  always_comb begin
    we1 = run && rf.wr_en1 && !((ZERO_REG != 0) && (w1_a == '0));
    we0 = run && rf.wr_en0 && !((ZERO_REG != 0) && (w0_a == '0))
              && !(we1 && (w1_a == w0_a));
  end

  // Read mux: bypass of this cycle's write (port 1 over port 0), else the
  // stored value; zero outside RUN and for the hardwired zero entry.
  function automatic logic [XLEN-1:0] read_mux(input logic [AW-1:0] ra);
    logic [XLEN-1:0] v;
    v = regs_q[ra];
    if (we0 && (w0_a == ra)) v = data0_v;
    if (we1 && (w1_a == ra)) v = data1_v;
    if (!run || ((ZERO_REG != 0) && (ra == '0))) v = '0;
    return v;
  endfunction

  // Combinational read ports.
  always_comb begin
    rout1_v = read_mux(r1_a);
    rout2_v = read_mux(r2_a);
  end

  assign rf.rout1 = rout1_v;
  assign rf.rout2 = rout2_v;
  assign rf.ready = (state_q == RUN);

  // Next-state logic: sweep clr_idx across every entry, then enter RUN.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == AW'(NREGS - 1)) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // State register; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Storage: sweep writes zero during CLEAR, ports write during RUN.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == CLEAR)) regs_q[clr_idx_q] <= '0;
    if (we0) regs_q[w0_a] <= data0_v;
    if (we1) regs_q[w1_a] <= data1_v;
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW-1:0]    alloc_a;

  assign alloc_a = rf.alloc_addr;

  // Busy update: writes clear their bit, then allocation sets (alloc wins).
  always_comb begin
    busy_d = busy_q;
    if (!run) begin
      busy_d = '0;
    end else begin
      if (we0) busy_d[w0_a] = 1'b0;
      if (we1) busy_d[w1_a] = 1'b0;
      if (rf.alloc_en && !((ZERO_REG != 0) && (alloc_a == '0))) begin
        busy_d[alloc_a] = 1'b1;
      end
    end
  end

  // Busy register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign rf.busy1 = busy_q[r1_a];
  assign rf.busy2 = busy_q[r2_a];
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters, ZERO_REG=1).
// A behavioural model predicts each cycle's outputs; predictions are queued
// when stimulus is applied and compared when the outputs are sampled.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS)) bus();

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (bus)
  );

  typedef struct {
    logic [XLEN-1:0] rout1;
    logic [XLEN-1:0] rout2;
    logic            ready;
    logic            busy1;
    logic            busy2;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  bit              m_run = 1'b0;
  int              m_idx = 0;
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  logic            last_ready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] ra);
    if (!m_run || rst) return '0;
    if (ra == '0) return '0;
    if (bus.wr_en1 && bus.w1 == ra) return bus.data1;
    if (bus.wr_en0 && bus.w0 == ra) return bus.data0;
    return m_regs[ra];
  endfunction

  // Model update at a rising edge, using the inputs held across that edge.
  task automatic m_edge();
    if (rst) begin
      m_run = 1'b0;
      m_idx = 0;
      for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    end else if (!m_run) begin
      m_regs[m_idx] = '0;
      m_idx++;
      if (m_idx == NREGS) begin
        m_run = 1'b1;
        m_idx = 0;
      end
      for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    end else begin
      if (bus.wr_en0 && bus.w0 != '0 && !(bus.wr_en1 && bus.w1 == bus.w0)) begin
        m_regs[bus.w0] = bus.data0;
        m_busy[bus.w0] = 1'b0;
      end
      if (bus.wr_en1 && bus.w1 != '0) begin
        m_regs[bus.w1] = bus.data1;
        m_busy[bus.w1] = 1'b0;
      end
`ifdef REGFILE_SCOREBOARD_EN
      if (bus.alloc_en && bus.alloc_addr != '0) m_busy[bus.alloc_addr] = 1'b1;
`endif
    end
  endtask

  task automatic step();
    exp_t e;
    e.rout1 = m_read(bus.r1);
    e.rout2 = m_read(bus.r2);
    e.ready = m_run;
    e.busy1 = m_busy[bus.r1];
    e.busy2 = m_busy[bus.r2];
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("rout1", 64'(bus.rout1), 64'(e.rout1));
    chk("rout2", 64'(bus.rout2), 64'(e.rout2));
    chk("ready", 64'(bus.ready), 64'(e.ready));
`ifdef REGFILE_SCOREBOARD_EN
    chk("busy1", 64'(bus.busy1), 64'(e.busy1));
    chk("busy2", 64'(bus.busy2), 64'(e.busy2));
`endif
    last_ready = bus.ready;
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic set_idle();
    bus.wr_en0 = 1'b0; bus.w0 = '0; bus.data0 = '0;
    bus.wr_en1 = 1'b0; bus.w1 = '0; bus.data1 = '0;
`ifdef REGFILE_SCOREBOARD_EN
    bus.alloc_en = 1'b0; bus.alloc_addr = '0;
`endif
  endtask

  task automatic rand_inputs();
    bus.wr_en0 = 1'($urandom_range(0, 1));
    bus.w0     = AW'($urandom_range(0, 7));
    bus.data0  = $urandom;
    bus.wr_en1 = 1'($urandom_range(0, 1));
    bus.w1     = AW'($urandom_range(0, 7));
    bus.data1  = $urandom;
    bus.r1     = AW'($urandom_range(0, 7));
    bus.r2     = AW'($urandom_range(0, NREGS - 1));
`ifdef REGFILE_SCOREBOARD_EN
    bus.alloc_en   = 1'($urandom_range(0, 1));
    bus.alloc_addr = AW'($urandom_range(0, 7));
`endif
  endtask

  // Counts steps from reset release until ready is observed high.
  task automatic sweep(input string tag, input bit with_writes);
    int n;
    n = 0;
    do begin
      if (with_writes) rand_inputs();
      step();
      n++;
    end while (!last_ready && n < 100);
    set_idle();
    chk(tag, 64'(n), 64'd33);
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < NREGS; i++) begin
      bus.r1 = AW'(i);
      bus.r2 = AW'(NREGS - 1 - i);
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = 'x;
      m_busy[i] = 1'b0;
    end
    rst = 1'b1;
    bus.r1 = '0;
    bus.r2 = '0;
    set_idle();
    @(posedge clk);
    m_edge();
    #1;

    // Power-up sweep and all-zero contents.
    rst = 1'b0;
    sweep("sweep_len", 1'b0);
    read_all_zero();

    // Single write with same-cycle bypass, then stored value.
    bus.wr_en0 = 1'b1; bus.w0 = 5'd5; bus.data0 = 32'hDEADBEEF; bus.r1 = 5'd5; bus.r2 = 5'd5;
    step();
    set_idle();
    step();
    chk("addr5_held", 64'(bus.rout1), 64'h0000_0000_DEAD_BEEF);

    // Collision on address 7: port 1 wins.
    bus.wr_en0 = 1'b1; bus.w0 = 5'd7; bus.data0 = 32'h11;
    bus.wr_en1 = 1'b1; bus.w1 = 5'd7; bus.data1 = 32'h22;
    bus.r1 = 5'd7; bus.r2 = 5'd7;
    step();
    set_idle();
    step();
    chk("addr7_held", 64'(bus.rout2), 64'h22);

    // Hardwired zero entry ignores writes and bypass.
    bus.wr_en1 = 1'b1; bus.w1 = 5'd0; bus.data1 = 32'hFFFFFFFF;
    bus.wr_en0 = 1'b1; bus.w0 = 5'd0; bus.data0 = 32'hFFFFFFFF;
    bus.r1 = 5'd0; bus.r2 = 5'd5;
    step();
    set_idle();
    step();

`ifdef REGFILE_SCOREBOARD_EN
    // Busy tracking on address 3.
    bus.r1 = 5'd3; bus.r2 = 5'd0;
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd3;
    step();
    set_idle();
    step();
    chk("busy_alloc", 64'(bus.busy1), 64'd1);
    bus.wr_en0 = 1'b1; bus.w0 = 5'd3; bus.data0 = 32'h33;
    step();
    set_idle();
    step();
    chk("busy_write", 64'(bus.busy1), 64'd0);
    bus.wr_en0 = 1'b1; bus.w0 = 5'd3; bus.data0 = 32'h44;
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd3;
    step();
    set_idle();
    step();
    chk("busy_both", 64'(bus.busy1), 64'd1);
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd0; bus.r2 = 5'd0;
    step();
    set_idle();
    step();
`endif

    // Mixed random traffic with collisions on a small address window.
    repeat (300) begin
      rand_inputs();
      step();
    end
    set_idle();

    // Reset from RUN, then reset again part-way through the sweep.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) begin
      rand_inputs();
      step();
    end
    rst = 1'b1;
    rand_inputs();
    step();
    rst = 1'b0;
    sweep("sweep_restart", 1'b1);
    read_all_zero();

    repeat (50) begin
      rand_inputs();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
